// File: rtl/fcpu_pkg.sv
// ============================================================================
// Module : fcpu_pkg
// Brief  : Shared widths and the CDB payload type for the fcpu datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fcpu_pkg;

    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rob_id;
        logic [DATA_W-1:0]   data;
    } cdb_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker; search starts at ptr and wraps.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic w_found;
    int   w_j;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(ptr) + k) % N;
            if (en && !w_found && req[w_j]) begin
                w_found  = 1'b1;
                gnt[w_j] = 1'b1;
                idx      = IW'(w_j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module : cdb_arbiter
// Brief  : One holding slot per producer, round-robin onto a registered CDB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*CDB_W-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       i_flush,
    output logic                       cdb_valid,
    output logic [CDB_W-1:0]           cdb,
    output logic [$clog2(N_REQ+1)-1:0] o_pending
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(N_REQ + 1);

    logic [N_REQ-1:0] r_slot_valid;
    cdb_t             r_slot_data [N_REQ];
    logic [PW-1:0]    r_rr_ptr;
    logic             r_cdb_valid;
    cdb_t             r_cdb;
    logic [CW-1:0]    r_pending;

    logic [N_REQ-1:0] w_gnt;
    logic [PW-1:0]    w_idx;
    logic [N_REQ-1:0] w_ready;
    logic [N_REQ-1:0] w_load;
    logic [N_REQ-1:0] w_slot_valid_nxt;
    logic [CW-1:0]    w_pending_nxt;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req (r_slot_valid),
        .ptr (r_rr_ptr),
        .en  (~i_flush),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    // A slot being drained this cycle can take a new result on the same edge.
    assign w_ready = {N_REQ{nrst & ~i_flush}} & (~r_slot_valid | w_gnt);
    assign w_load  = req_valid & w_ready;

    always_comb begin
        w_slot_valid_nxt = (r_slot_valid & ~w_gnt) | w_load;
        if (i_flush) begin
            w_slot_valid_nxt = '0;
        end
        w_pending_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pending_nxt = w_pending_nxt + CW'(w_slot_valid_nxt[i]);
        end
    end

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_slot
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    r_slot_data[g] <= '0;
                end else if (w_load[g]) begin
                    r_slot_data[g] <= req_data[g*CDB_W +: CDB_W];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_slot_valid <= '0;
            r_pending    <= '0;
            r_rr_ptr     <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb        <= '0;
        end else begin
            r_slot_valid <= w_slot_valid_nxt;
            r_pending    <= w_pending_nxt;
            r_cdb_valid  <= |w_gnt;
            if (|w_gnt) begin
                r_cdb    <= r_slot_data[w_idx];
                r_rr_ptr <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + PW'(1);
            end
        end
    end

    assign req_ready = w_ready;
    assign cdb_valid = r_cdb_valid;
    assign cdb       = r_cdb;
    assign o_pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module : tb_cdb_arbiter
// Brief  : Vector table, directed corner sequences and random run vs a model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic [N-1:0]       req_valid = '0;
    logic [N*CDB_W-1:0] req_data = '0;
    logic [N-1:0]       req_ready;
    logic               i_flush = 1'b0;
    logic               cdb_valid;
    logic [CDB_W-1:0]   cdb;
    logic [2:0]         o_pending;

    cdb_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .i_flush   (i_flush),
        .cdb_valid (cdb_valid),
        .cdb       (cdb),
        .o_pending (o_pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CDB_W-1:0] mk(input int rob, input logic [31:0] d);
        return {RSV_ID_W'(rob), d};
    endfunction

    // Reference model: occupancy flags per requester, a pointer and a broadcast latch.
    bit               mv [N];
    logic [CDB_W-1:0] md [N];
    int               mptr;
    logic             mcv;
    logic [CDB_W-1:0] mcdb;
    int               mpend;

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            md[i] = '0;
        end
        mptr = 0; mcv = 0; mcdb = '0; mpend = 0;
    endtask

    function automatic int m_grant();
        if (i_flush) return -1;
        for (int k = 0; k < N; k++) begin
            if (mv[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        g = m_grant();
        for (int i = 0; i < N; i++) r[i] = nrst && !i_flush && (!mv[i] || g == i);
        return r;
    endfunction

    task automatic m_edge();
        int g;
        logic [N-1:0] rdy;
        g   = m_grant();
        rdy = m_ready();
        if (i_flush) begin
            for (int i = 0; i < N; i++) mv[i] = 0;
            mcv = 0;
        end else begin
            mcv = (g >= 0);
            if (g >= 0) begin
                mcdb  = md[g];
                mv[g] = 0;
                mptr  = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && rdy[i]) begin
                    mv[i] = 1;
                    md[i] = req_data[i*CDB_W +: CDB_W];
                end
            end
        end
        mpend = 0;
        for (int i = 0; i < N; i++) mpend += mv[i];
    endtask

    task automatic tick();
        @(posedge clk);
        if (!nrst) m_reset();
        else       m_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0; req_valid = '0; i_flush = 1'b0;
        m_reset();
        #1;
        chk("reset_ready", 64'(req_ready), 64'h0);
        chk("reset_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("reset_cdb", 64'(cdb), 64'h0);
        chk("reset_pending", 64'(o_pending), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    typedef struct {
        logic [3:0] v;
        logic       fl;
        logic [3:0] rdy;
        logic       cv;
        logic [3:0] rob;
        logic [2:0] pend;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // Requester i always offers rob id i in the vector table.
        tbl[0]  = '{4'b1111, 1'b0, 4'b1111, 1'b0, 4'd0, 3'd4};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 4'd0, 3'd4};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 4'd1, 3'd4};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 4'd2, 3'd4};
        tbl[4]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 4'd3, 3'd4};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 4'd0, 3'd4};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0010, 1'b1, 4'd1, 3'd3};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0110, 1'b1, 4'd2, 3'd2};
        tbl[8]  = '{4'b0000, 1'b0, 4'b1110, 1'b1, 4'd3, 3'd1};
        tbl[9]  = '{4'b0000, 1'b0, 4'b1111, 1'b1, 4'd0, 3'd0};
        tbl[10] = '{4'b0000, 1'b0, 4'b1111, 1'b0, 4'd0, 3'd0};
        tbl[11] = '{4'b1000, 1'b0, 4'b1111, 1'b0, 4'd0, 3'd1};
        tbl[12] = '{4'b0101, 1'b0, 4'b1111, 1'b1, 4'd3, 3'd2};
        tbl[13] = '{4'b0000, 1'b0, 4'b1011, 1'b1, 4'd0, 3'd1};
        tbl[14] = '{4'b0000, 1'b0, 4'b1111, 1'b1, 4'd2, 3'd0};
        tbl[15] = '{4'b0000, 1'b0, 4'b1111, 1'b0, 4'd0, 3'd0};
        tbl[16] = '{4'b0111, 1'b0, 4'b1111, 1'b0, 4'd0, 3'd3};
        tbl[17] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'd0, 3'd0};
        tbl[18] = '{4'b0000, 1'b0, 4'b1111, 1'b0, 4'd0, 3'd0};

        m_reset();

        // Single result, two-cycle latency.
        do_reset();
        req_valid = 4'b0001;
        req_data[0 +: CDB_W] = mk(3, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", 64'(req_ready), 64'hF);
        tick();
        chk("single_cv_e0", 64'(cdb_valid), 64'h0);
        chk("single_pend_e0", 64'(o_pending), 64'h1);
        @(negedge clk);
        req_valid = '0;
        tick();
        chk("single_cv_e1", 64'(cdb_valid), 64'h1);
        chk("single_cdb", 64'(cdb), 64'(mk(3, 32'hDEAD_BEEF)));
        chk("single_pend_e1", 64'(o_pending), 64'h0);
        @(negedge clk);
        tick();
        chk("single_cv_pulse", 64'(cdb_valid), 64'h0);

        // Fairness, wrap-around and flush vectors from a fresh pointer.
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*CDB_W +: CDB_W] = mk(i, 32'hA000_0000 + i);
        for (int s = 0; s < 19; s++) begin
            if (s != 0) @(negedge clk);
            req_valid = tbl[s].v;
            i_flush   = tbl[s].fl;
            #1;
            chk($sformatf("vec%0d_ready", s), 64'(req_ready), 64'(tbl[s].rdy));
            tick();
            chk($sformatf("vec%0d_cv", s), 64'(cdb_valid), 64'(tbl[s].cv));
            if (tbl[s].cv)
                chk($sformatf("vec%0d_cdb", s), 64'(cdb), 64'(mk(int'(tbl[s].rob), 32'hA000_0000 + 32'(tbl[s].rob))));
            chk($sformatf("vec%0d_pend", s), 64'(o_pending), 64'(tbl[s].pend));
        end
        @(negedge clk);
        i_flush = 1'b0;

        // Back-to-back reload on one requester.
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            req_valid = 4'b0010;
            req_data[1*CDB_W +: CDB_W] = mk(1, 32'(k));
            #1;
            chk("b2b_ready1", 64'(req_ready[1]), 64'h1);
            tick();
            chk("b2b_cv", 64'(cdb_valid), (k == 0) ? 64'h0 : 64'h1);
            if (k != 0) chk("b2b_cdb", 64'(cdb), 64'(mk(1, 32'(k - 1))));
        end
        @(negedge clk);
        req_valid = '0;
        tick();
        chk("b2b_last", 64'(cdb), 64'(mk(1, 32'd9)));

        // Asynchronous reset while all slots are busy.
        @(negedge clk);
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i*CDB_W +: CDB_W] = mk(8 + i, 32'hB000_0000 + i);
        tick();
        chk("arst_pend_before", 64'(o_pending), 64'(mpend));
        @(negedge clk);
        req_valid = '0;
        #2;
        nrst = 1'b0;
        m_reset();
        #1;
        chk("arst_cv", 64'(cdb_valid), 64'h0);
        chk("arst_pend", 64'(o_pending), 64'h0);
        chk("arst_ready", 64'(req_ready), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        req_valid = 4'b0101;
        req_data[0 +: CDB_W]       = mk(5, 32'h0000_0050);
        req_data[2*CDB_W +: CDB_W] = mk(7, 32'h0000_0070);
        #1;
        chk("arst_ready_after", 64'(req_ready), 64'hF);
        tick();
        chk("arst_cv_e0", 64'(cdb_valid), 64'h0);
        @(negedge clk);
        req_valid = '0;
        tick();
        chk("arst_first", 64'(cdb), 64'(mk(5, 32'h0000_0050)));
        @(negedge clk);
        tick();
        chk("arst_second", 64'(cdb), 64'(mk(7, 32'h0000_0070)));

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c != 0) @(negedge clk);
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                req_data[i*CDB_W +: CDB_W] = mk($urandom_range(0, 15), $urandom);
            i_flush = ($urandom_range(0, 15) == 0);
            #1;
            chk("rnd_ready", 64'(req_ready), 64'(m_ready()));
            tick();
            chk("rnd_cv", 64'(cdb_valid), 64'(mcv));
            chk("rnd_cdb", 64'(cdb), 64'(mcdb));
            chk("rnd_pend", 64'(o_pending), 64'(mpend));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
